sequence_output_player: RTL and testbench

Downstream stage of the sort sequencer: once sorting has finished, it reads the sorted node sequence out of the sequence RAM one entry at a time. It presents each entry on a valid/ready output stream for the display/output logic. It also returns a done level so the top-level can release its start request and re-arm the sorter.

---
 rtl/sequence_output_player.sv | 129 ++++++++++++
 tb/tb_sequence_output_player.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_output_player.sv
// sequence_output_player
//   Reads the sorted node sequence out of the sequence RAM one entry at a
//   time once sorting has finished. Each entry is presented on a
//   valid/ready stream. A done level is returned to the top-level so it can
//   release its start request and re-arm the sorter.
//
// Handshake: an entry transfers on a rising clk edge where out_valid and
//   out_ready are both high. While out_valid is high, out_data, out_index and
//   out_last hold stable until that transfer. out_valid never depends on
//   out_ready.
//
// Ports:
//   clk            system clock, rising edge
//   program_reset  synchronous active-high reset
//   start_play     level request to play the sequence
//   sort_done      level, high while sorting is complete
//   node_count     number of valid entries, latched when sort_done is seen
//   rd_en/rd_addr  RAM read strobe and address (rd_addr always equals idx)
//   rd_data        RAM read data, valid one cycle after rd_en
//   out_valid/out_data/out_index/out_last/out_ready  output entry stream
//   play_done      whole sequence emitted; held until start_play drops
//   current_state  FSM state code for debug
module sequence_output_player #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  program_reset,
    input  logic                  start_play,
    input  logic                  sort_done,
    input  logic [ADDR_WIDTH:0]   node_count,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  play_done,
    output logic [2:0]            current_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SORT = 3'd1,
        FETCH     = 3'd2,
        LATCH     = 3'd3,
        PRESENT   = 3'd4,
        DONE      = 3'd7
    } state_t;

    // Largest number of entries the address space can hold.
    localparam logic [ADDR_WIDTH:0]   MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   clamped_count;
    logic                  idx_is_last;

    assign clamped_count = (node_count > MAX_COUNT) ? MAX_COUNT : node_count;
    // count is at least 1 whenever this is used (FETCH/LATCH only).
    assign idx_is_last   = ({1'b0, idx} == (count - CNT_ONE));

    always_ff @(posedge clk) begin
        if (program_reset) begin
            state     <= IDLE;
            idx       <= '0;
            count     <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_play) begin
                        state <= WAIT_SORT;
                    end
                end
                WAIT_SORT: begin
                    if (sort_done) begin
                        count <= clamped_count;
                        idx   <= '0;
                        state <= (clamped_count == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    state <= LATCH;
                end
                LATCH: begin
                    // rd_data is valid now: one cycle after the FETCH strobe.
                    out_data  <= rd_data;
                    out_index <= idx;
                    out_last  <= idx_is_last;
                    state     <= PRESENT;
                end
                PRESENT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_ONE;
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!start_play) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore decodes straight from the state register.
    assign rd_en         = (state == FETCH);
    assign out_valid     = (state == PRESENT);
    assign play_done     = (state == DONE);
    assign rd_addr       = idx;
    assign current_state = state;

endmodule

// File: tb/tb_sequence_output_player.sv
module tb_sequence_output_player;

    localparam int AW = 4;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          program_reset = 1'b1;
    logic          start_play    = 1'b0;
    logic          sort_done     = 1'b0;
    logic [AW:0]   node_count    = '0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_index;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          play_done;
    logic [2:0]    current_state;

    sequence_output_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .program_reset(program_reset), .start_play(start_play),
        .sort_done(sort_done), .node_count(node_count), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
        .out_data(out_data), .out_index(out_index), .out_last(out_last),
        .out_ready(out_ready), .play_done(play_done), .current_state(current_state)
    );

    // Sequence RAM model: one-cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    // Expected entries packed as {data, index, last}.
    logic [12:0] exp_q[$];
    int          hs_q[$];
    int          exp_done_cyc = -1;
    int          rd_cnt = 0;
    int          val_cnt = 0;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        logic [12:0] e;
        if (rd_en) rd_cnt++;
        if (out_valid) val_cnt++;
        if (out_valid && out_ready && !program_reset) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("entry", {19'd0, out_data, out_index, out_last}, {19'd0, e});
                hs_q.push_back(cyc);
                if (e[0]) exp_done_cyc = cyc + 1;
            end
        end
        if (play_done && !prev_done) check("done_timing", cyc, exp_done_cyc);
        prev_done = play_done;
    end

    // ---------------- ready driver ----------------
    // 0: always ready, 1: random, 2: hold index 1 for 5 cycles, 3: stall on index 2
    int ready_mode = 0;
    int hold_n = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: begin
                if (out_valid && out_index == 1 && hold_n < 5) begin
                    out_ready = 1'b0;
                    check("hold_data", out_data, 8'h22);
                    check("hold_index", out_index, 1);
                    check("hold_no_rd", rd_en, 0);
                    hold_n++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            default: out_ready = !(out_valid && out_index == 2);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Reference model: the entries that must appear are simply the first
    // min(n, 16) RAM words, in order, last flag on the final one.
    task automatic push_expected(input int n);
        int cl;
        cl = (n > 16) ? 16 : n;
        for (int i = 0; i < cl; i++)
            exp_q.push_back({mem[i], 4'(i), 1'(i == cl - 1)});
    endtask

    task automatic start(input int n);
        hs_q.delete();
        push_expected(n);
        node_count = (AW + 1)'(n);
        start_play = 1'b1;
        sort_done  = 1'b1;
        if (n == 0) exp_done_cyc = cyc + 2;
    endtask

    task automatic finish_play();
        int k;
        k = 0;
        while (!play_done && k < 400) begin
            step();
            k++;
        end
        check("done_reached", play_done, 1);
        check("queue_drained", exp_q.size(), 0);
        step();
        check("done_held", play_done, 1);
        check("done_state", current_state, 7);
        start_play = 1'b0;
        sort_done  = 1'b0;
        step();
        check("release_state", current_state, 0);
        check("release_done", play_done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int c0, r0, v0, k;
        for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;

        step(); step();
        check("rst_state", current_state, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", play_done, 0);
        check("rst_outs", {out_data, out_index, out_last, rd_addr}, 0);
        program_reset = 1'b0;
        step();

        // Four entries, ready always high.
        ready_mode = 0;
        c0 = cyc;
        start(4);
        finish_play();
        check("hs_count", hs_q.size(), 4);
        if (hs_q.size() == 4) begin
            check("first_valid_lat", hs_q[0] - c0, 4);
            for (int i = 0; i < 3; i++) check("throughput", hs_q[i+1] - hs_q[i], 3);
        end

        // Backpressure on index 1.
        ready_mode = 2;
        hold_n = 0;
        r0 = rd_cnt;
        start(4);
        finish_play();
        check("hold_cycles", hold_n, 5);
        check("bp_rd_count", rd_cnt - r0, 4);

        // Empty count.
        ready_mode = 0;
        r0 = rd_cnt; v0 = val_cnt;
        start(0);
        step();
        check("empty_wait", current_state, 1);
        step();
        check("empty_done", current_state, 7);
        finish_play();
        check("empty_no_rd", rd_cnt - r0, 0);
        check("empty_no_valid", val_cnt - v0, 0);

        // Count clamp.
        hs_q.delete();
        start(20);
        finish_play();
        check("clamp_entries", hs_q.size(), 16);

        // Reset while PRESENT holds index 2.
        ready_mode = 3;
        start(4);
        k = 0;
        while (!(current_state == 4 && out_index == 2) && k < 100) begin
            step();
            k++;
        end
        check("reached_idx2", {current_state, 1'b0, out_index}, {3'd4, 1'b0, 4'd2});
        program_reset = 1'b1;
        start_play = 1'b0;
        sort_done = 1'b0;
        step();
        check("mid_rst_state", current_state, 0);
        check("mid_rst_strobes", {rd_en, out_valid, play_done}, 0);
        check("mid_rst_outs", {out_data, out_index, out_last, rd_addr}, 0);
        exp_q.delete();
        program_reset = 1'b0;
        ready_mode = 0;
        step();
        start(4);
        finish_play();

        // Re-entry after release.
        start_play = 1'b1;
        step();
        check("reentry_wait", current_state, 1);
        step();
        check("reentry_stays", current_state, 1);
        start_play = 1'b0;
        program_reset = 1'b1;
        step();
        program_reset = 1'b0;

        // Randomized plays with random backpressure.
        ready_mode = 1;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
            start($urandom_range(0, 20));
            finish_play();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
